local_port_arbiter: RTL
=======================

Name: local_port_arbiter

Overview:
- Shares one router local input port among N_REQ packet sources (cores or traffic generators) on the same tile.
- Grants are packet-granular and round-robin. Once a source wins, it owns the port until its packet tail has been forwarded.
- Sits between the sources and the NOC local rx/credit port. Uses the NoC credit handshake on both sides.

Parameters:
- N_REQ, 4, number of requesters; range 2..16.
- FLIT_W, 32, flit width in bits.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high.
- req_rx  in  N_REQ  per-requester flit valid.
- req_data  in  N_REQ*FLIT_W  flattened flits; requester i occupies bits [i*FLIT_W +: FLIT_W].
- req_credit_o  out  N_REQ  per-requester credit (ready).
- rx_o  out  1  flit valid toward the router local port.
- data_o  out  FLIT_W  flit toward the router local port.
- credit_i  in  1  router local-port credit.
- grant_o  out  N_REQ  one-hot current owner; all zero when idle.
- busy_o  out  1  high while a packet is owned (any state other than IDLE).

Behaviour:
- Transfer rule: a flit transfers on a rising clock edge when rx and credit are both 1 on the same side.
- Packet format:
  - flit 0 is the header.
  - flit 1 is SIZE, an unsigned count of the flits that follow it.
  - Total flits = SIZE + 2.
- State machine: IDLE, HEADER, SIZE, BODY.
- IDLE:
  - grant_o = 0, rx_o = 0, all req_credit_o = 0.
  - If any req_rx is high, pick the first requester at or after rr_ptr, cyclically.
  - Register that pick into grant_o and go to HEADER. Arbitration costs exactly 1 cycle.
- Datapath when granted: purely combinational, zero added latency.
  - rx_o = req_rx[g].
  - data_o = req_data[g].
  - req_credit_o[g] = credit_i.
  - All other req_credit_o = 0.
- HEADER: on transfer, go to SIZE.
- SIZE:
  - On transfer, load remaining = data_o (32-bit).
  - If data_o == 0, this flit is the tail: go to IDLE.
  - Otherwise go to BODY.
- BODY:
  - On each transfer, remaining decrements.
  - The transfer with remaining == 1 is the tail: go to IDLE.
- On tail transfer:
  - rr_ptr = (g + 1) mod N_REQ.
  - grant_o clears on the next cycle.
  - There is no back-to-back re-grant: IDLE always lasts at least 1 cycle.
- data_o when not granted: 0. rx_o when not granted: 0.
- Bubbles: the owner may drop req_rx mid-packet. Grant is held, the counter is frozen and rx_o follows req_rx.
- Backpressure: credit_i = 0 freezes the counter and state. The requester sees credit 0 and must hold its data.
- Non-owner requests: a non-owner raising req_rx mid-packet is ignored; it waits, with credit 0.
- Simultaneous requests in IDLE: lowest index at or after rr_ptr wins.
- Reset, asynchronous at any time, including mid-packet:
  - state = IDLE, rr_ptr = 0, grant_o = 0, remaining = 0.
  - rx_o = 0, data_o = 0, req_credit_o = 0, busy_o = 0.
  - A truncated packet is abandoned; the router side is reset with it.
- Large SIZE: SIZE = 0xFFFFFFFF is legal; the counter is 32-bit and never wraps before the tail.

Decomposition:
- Package noc_pkg:
  - FLIT_W.
  - Header field slices: src_x [31:24], src_y [23:16], tgt_x [15:8], tgt_y [7:0].
  - enum arb_state_t {IDLE, HEADER, SIZE, BODY}.
- Sub-module rr_picker: combinational round-robin one-hot picker with inputs req and ptr and output gnt. It is reused by the router's crossbar arbiter.

Test Plan:
- Single requester 2 sends header 0x00001100, SIZE 3, then 3 flits; credit_i = 1 throughout. Required response:
  - grant_o = 0100 one cycle after req_rx.
  - 5 flits appear on data_o in order.
  - grant_o = 0 the cycle after the tail.
  - rr_ptr = 3.
- All 4 requesters assert req_rx at once, each sending SIZE = 2. Required response:
  - Grants occur in order 0, 1, 2, 3.
  - Each packet is 4 contiguous flits.
  - Exactly 1 idle cycle separates packets.
- SIZE = 0 from requester 1. Required response:
  - Packet ends after 2 flits.
  - FSM returns to IDLE with no BODY state.
- credit_i pulled low for 3 cycles mid-BODY, and the owner drops req_rx for 2 cycles. Required response:
  - No flit is lost or duplicated.
  - Non-owner credits stay 0.
  - The payload sequence 1..N is intact at the output.
- reset asserted asynchronously mid-BODY. Required response:
  - All outputs are 0 immediately, without waiting for an edge.
  - After release, requester 0 wins first (rr_ptr = 0).
- Fairness: requester 3 streams continuously while requester 0 requests once. Required response: requester 0 is granted no later than after 1 packet from requester 3.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, header field accessors and the
// local-port arbiter state encoding.
package noc_pkg;

    localparam int FLIT_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        SIZE,
        BODY
    } arb_state_t;

    function automatic logic [7:0] hdr_src_x(input logic [31:0] hdr);
        return hdr[31:24];
    endfunction

    function automatic logic [7:0] hdr_src_y(input logic [31:0] hdr);
        return hdr[23:16];
    endfunction

    function automatic logic [7:0] hdr_tgt_x(input logic [31:0] hdr);
        return hdr[15:8];
    endfunction

    function automatic logic [7:0] hdr_tgt_y(input logic [31:0] hdr);
        return hdr[7:0];
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first requester
// at or after ptr, wrapping around.
module rr_picker #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    always_comb begin
        logic found;
        int   idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/local_port_arbiter.sv
// Packet-granular round-robin arbiter sharing one router local input port
// among N_REQ on-tile sources, using the credit handshake on both sides.
module local_port_arbiter
    import noc_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int FLIT_W = noc_pkg::FLIT_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_rx,
    input  logic [N_REQ*FLIT_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_credit_o,
    output logic                    rx_o,
    output logic [FLIT_W-1:0]       data_o,
    input  logic                    credit_i,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]      remaining_q, remaining_d;

    logic [N_REQ-1:0] pick;
    logic [PTR_W-1:0] owner_idx;
    logic [PTR_W-1:0] next_ptr;
    logic [31:0]      size_flit;
    logic             xfer;
    logic             tail;

    rr_picker #(
        .N    (N_REQ),
        .PTR_W(PTR_W)
    ) u_picker (
        .req(req_rx),
        .ptr(rr_ptr_q),
        .gnt(pick)
    );

    // The owner's flit path is a pure mux so granting adds no latency.
    always_comb begin
        rx_o         = 1'b0;
        data_o       = '0;
        req_credit_o = '0;
        owner_idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                rx_o            = req_rx[i];
                data_o          = req_data[i*FLIT_W +: FLIT_W];
                req_credit_o[i] = credit_i;
                owner_idx       = PTR_W'(i);
            end
        end
    end

    assign xfer      = rx_o & credit_i;
    assign size_flit = 32'(data_o);
    assign next_ptr  = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
    assign grant_o   = grant_q;
    assign busy_o    = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        remaining_d = remaining_q;
        tail        = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_rx) begin
                    grant_d = pick;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (xfer) state_d = SIZE;
            end
            SIZE: begin
                if (xfer) begin
                    remaining_d = size_flit;
                    if (size_flit == 32'd0) tail = 1'b1;
                    else state_d = BODY;
                end
            end
            BODY: begin
                if (xfer) begin
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) tail = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Releasing on the tail forces at least one IDLE cycle before the next grant.
        if (tail) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = next_ptr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            remaining_q <= remaining_d;
        end
    end

endmodule
